// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin write arbiter that lets four requesters share one
//             8-entry FIFO write port. A winner is chosen in IDLE (one-cycle
//             bubble), then owns the port in XFER for up to BURST words.
//             Writes stall while the FIFO is full or while a valid read is
//             happening in the same cycle, because the shared FIFO drops a
//             simultaneous read and write.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous, active-low reset
//             req[3:0]     - per-requester "din_i holds a valid word"
//             din0..din3   - requester write data (8 bits each)
//             ack[3:0]     - one-hot, din_i written on this edge
//             fifo_full    - FIFO full flag
//             fifo_empty   - FIFO empty flag
//             fifo_rd_en   - consumer read enable seen by the same FIFO
//             fifo_wr_en   - FIFO write enable
//             fifo_din     - FIFO write data (din of current owner)
//             owner[1:0]   - index of granted requester (valid while busy)
//             busy         - high while a grant is in progress (XFER)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int BURST = 4  // words per grant, legal range 1..8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  input  logic [7:0] din2,
  input  logic [7:0] din3,
  output logic [3:0] ack,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  input  logic       fifo_rd_en,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_din,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Beat index of the final word in a burst.
  localparam logic [2:0] c_last_beat = 3'(BURST - 1);

  state_t     r_state;
  logic [1:0] r_owner;
  logic [1:0] r_last;
  logic [2:0] r_beat_cnt;

  state_t     w_state_nxt;
  logic [1:0] w_owner_nxt;
  logic [1:0] w_last_nxt;
  logic [2:0] w_beat_nxt;

  logic [1:0] w_grant;
  logic       w_found;
  logic [1:0] w_idx;
  logic       w_req_own;
  logic       w_collide;
  logic       w_wr_ok;

  // Round-robin search starting one past the last owner, wrapping mod 4.
  always_comb begin
    w_grant = 2'd0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // The data mux follows owner at all times, even when no write is issued.
  always_comb begin
    case (r_owner)
      2'd0:    fifo_din = din0;
      2'd1:    fifo_din = din1;
      2'd2:    fifo_din = din2;
      default: fifo_din = din3;
    endcase
  end

  assign w_req_own = req[r_owner];
  // A valid read in the same cycle would make the FIFO discard the write.
  assign w_collide = fifo_rd_en & ~fifo_empty;
  assign w_wr_ok   = (r_state == XFER) & w_req_own & ~fifo_full & ~w_collide;

  assign fifo_wr_en = w_wr_ok;
  assign ack        = w_wr_ok ? (4'b0001 << r_owner) : 4'b0000;
  assign owner      = r_owner;
  assign busy       = (r_state == XFER);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (req != 4'b0000) begin
          w_owner_nxt = w_grant;
          w_beat_nxt  = 3'd0;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (!w_req_own) begin
          // Owner withdrew: release the port without writing.
          w_last_nxt  = r_owner;
          w_state_nxt = IDLE;
        end else if (w_wr_ok) begin
          w_beat_nxt = r_beat_cnt + 3'd1;
          if (r_beat_cnt == c_last_beat) begin
            w_last_nxt  = r_owner;
            w_state_nxt = IDLE;
          end
        end
        // Otherwise stalled on full/collision: hold everything.
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // last resets to 3 so the first arbitration favours requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_owner    <= 2'd0;
      r_last     <= 2'd3;
      r_beat_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Directed self-checking bench for fifo_wr_arbiter (BURST = 4).
//             Inputs change just after the falling edge; outputs are checked
//             1 ns later, well away from the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] din0, din1, din2, din3;
  logic [3:0] ack;
  logic       fifo_full, fifo_empty, fifo_rd_en;
  logic       fifo_wr_en;
  logic [7:0] fifo_din;
  logic [1:0] owner;
  logic       busy;

  int checks;
  int errors;

  fifo_wr_arbiter #(.BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .owner      (owner),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; din0 = 8'h5A; din1 = 8'h11; din2 = 8'h22; din3 = 8'h33;
    fifo_full = 1'b0; fifo_empty = 1'b1; fifo_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if (fifo_din !== 8'h5A) begin errors++; $display("FAIL reset_fifo_din: got %h expected 5a", fifo_din); end
  endtask

  // Single requester, four words A1..A4 after one bubble.
  task automatic test_single();
    @(negedge clk);
    rst = 1'b1; req = 4'b0001; din0 = 8'hA1;
    #1;
    checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_bubble: busy %b wr_en %b expected 0 0", busy, fifo_wr_en); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din0 = 8'hA1 + 8'(i);
      #1;
      checks++; if (fifo_wr_en !== 1'b1 || ack !== 4'b0001) begin errors++; $display("FAIL single_write %0d: wr_en %b ack %b expected 1 0001", i, fifo_wr_en, ack); end
      checks++; if (fifo_din !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL single_data %0d: got %h expected %h", i, fifo_din, 8'hA1 + 8'(i)); end
    end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_end_idle: busy %b wr_en %b expected 0 0", busy, fifo_wr_en); end
    req = 4'b0000;
  endtask

  // All four requesting: owners 0,1,2,3,0 with one bubble between grants.
  task automatic test_round_robin();
    logic [1:0] exp_owner;
    logic [7:0] exp_din;
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    req = 4'b1111; din0 = 8'h10; din1 = 8'h21; din2 = 8'h32; din3 = 8'h43;
    for (int g = 0; g < 5; g++) begin
      exp_owner = 2'(g);
      case (exp_owner)
        2'd0: exp_din = 8'h10;
        2'd1: exp_din = 8'h21;
        2'd2: exp_din = 8'h32;
        default: exp_din = 8'h43;
      endcase
      if (g != 0) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rr_bubble %0d: busy %b wr_en %b expected 0 0", g, busy, fifo_wr_en); end
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1 || owner !== exp_owner) begin errors++; $display("FAIL rr_owner g%0d w%0d: busy %b owner %0d expected 1 %0d", g, w, busy, owner, exp_owner); end
        checks++; if (fifo_wr_en !== 1'b1 || ack !== (4'b0001 << exp_owner)) begin errors++; $display("FAIL rr_ack g%0d w%0d: wr_en %b ack %b expected 1 %b", g, w, fifo_wr_en, ack, 4'b0001 << exp_owner); end
        checks++; if (fifo_din !== exp_din) begin errors++; $display("FAIL rr_data g%0d w%0d: got %h expected %h", g, w, fifo_din, exp_din); end
      end
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_idle: busy %b expected 0", busy); end
  endtask

  // Owner 2, FIFO fills after 3 words, then exactly one more word.
  task automatic test_full_stall();
    @(negedge clk);
    req = 4'b0100; din2 = 8'hC0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_bubble: busy %b expected 0", busy); end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      #1;
      checks++; if (fifo_wr_en !== 1'b1 || ack !== 4'b0100 || owner !== 2'd2) begin errors++; $display("FAIL full_pre %0d: wr_en %b ack %b owner %0d expected 1 0100 2", w, fifo_wr_en, ack, owner); end
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      fifo_full = 1'b1;
      #1;
      checks++; if (fifo_wr_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL full_stall %0d: wr_en %b ack %b busy %b expected 0 0000 1", s, fifo_wr_en, ack, busy); end
    end
    @(negedge clk);
    fifo_full = 1'b0;
    #1;
    checks++; if (fifo_wr_en !== 1'b1 || ack !== 4'b0100) begin errors++; $display("FAIL full_resume: wr_en %b ack %b expected 1 0100", fifo_wr_en, ack); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_end_idle: busy %b wr_en %b expected 0 0", busy, fifo_wr_en); end
    req = 4'b0000;
  endtask

  // Owner 3, valid-read collision for 2 cycles; read on empty FIFO is harmless.
  task automatic test_collision();
    @(negedge clk);
    req = 4'b1000; din3 = 8'hD3; fifo_empty = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_bubble: busy %b expected 0", busy); end
    @(negedge clk);
    #1;
    checks++; if (fifo_wr_en !== 1'b1 || ack !== 4'b1000 || owner !== 2'd3) begin errors++; $display("FAIL coll_word1: wr_en %b ack %b owner %0d expected 1 1000 3", fifo_wr_en, ack, owner); end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      fifo_rd_en = 1'b1;
      #1;
      checks++; if (fifo_wr_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL coll_stall %0d: wr_en %b ack %b busy %b expected 0 0000 1", s, fifo_wr_en, ack, busy); end
    end
    @(negedge clk);
    fifo_rd_en = 1'b0;
    #1;
    checks++; if (fifo_wr_en !== 1'b1 || ack !== 4'b1000) begin errors++; $display("FAIL coll_resume: wr_en %b ack %b expected 1 1000", fifo_wr_en, ack); end
    @(negedge clk);
    fifo_rd_en = 1'b1; fifo_empty = 1'b1;
    #1;
    checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL coll_rd_on_empty: wr_en %b expected 1", fifo_wr_en); end
    @(negedge clk);
    fifo_rd_en = 1'b0;
    #1;
    checks++; if (fifo_wr_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL coll_word4: wr_en %b busy %b expected 1 1", fifo_wr_en, busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_end_idle: busy %b expected 0", busy); end
    req = 4'b0000;
  endtask

  // Owner 1 drops its request after 2 words; requester 3 is granted next.
  task automatic test_drop();
    @(negedge clk);
    req = 4'b1010; din1 = 8'hB1; din3 = 8'hB3;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_bubble: busy %b expected 0", busy); end
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      #1;
      checks++; if (fifo_wr_en !== 1'b1 || ack !== 4'b0010 || owner !== 2'd1) begin errors++; $display("FAIL drop_word %0d: wr_en %b ack %b owner %0d expected 1 0010 1", w, fifo_wr_en, ack, owner); end
    end
    @(negedge clk);
    req = 4'b1000;
    #1;
    checks++; if (fifo_wr_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL drop_nowrite: wr_en %b ack %b busy %b expected 0 0000 1", fifo_wr_en, ack, busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: busy %b expected 0", busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || owner !== 2'd3 || ack !== 4'b1000 || fifo_din !== 8'hB3) begin errors++; $display("FAIL drop_next_owner: busy %b owner %0d ack %b din %h expected 1 3 1000 b3", busy, owner, ack, fifo_din); end
    @(negedge clk);
    req = 4'b0000;
    #1;
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL drop_release: wr_en %b expected 0", fifo_wr_en); end
    @(negedge clk);
  endtask

  // Reset pulse between edges aborts the burst immediately.
  task automatic test_async_reset();
    req = 4'b0001; din0 = 8'hE0; din1 = 8'hE1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_bubble: busy %b expected 0", busy); end
    @(negedge clk);
    #1;
    checks++; if (fifo_wr_en !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL areset_word1: wr_en %b owner %0d expected 1 0", fifo_wr_en, owner); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (clk !== 1'b0) begin errors++; $display("FAIL areset_timing: clk %b expected 0", clk); end
    checks++; if (fifo_wr_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL areset_async: wr_en %b ack %b busy %b expected 0 0000 0", fifo_wr_en, ack, busy); end
    @(negedge clk);
    rst = 1'b1; req = 4'b1010;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_rel_bubble: busy %b expected 0", busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || owner !== 2'd1 || ack !== 4'b0010 || fifo_din !== 8'hE1) begin errors++; $display("FAIL areset_regrant: busy %b owner %0d ack %b din %h expected 1 1 0010 e1", busy, owner, ack, fifo_din); end
    req = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_collision();
    test_drop();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: BURST, 4, maximum consecutive words accepted from one owner per grant; legal range 1..8.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low.
REQ-004 Port: req  input  4  per-requester write request; req[i] high means din_i holds a valid word.
REQ-005 Port: din0, din1, din2, din3  input  8 each  requester write data.
REQ-006 Port: ack  output  4  one-hot; ack[i] high means din_i is written into the FIFO on this edge.
REQ-007 Port: fifo_full  input  1  full flag of the shared 8-entry FIFO.
REQ-008 Port: fifo_empty  input  1  empty flag of the shared FIFO.
REQ-009 Port: fifo_rd_en  input  1  consumer read enable presented to the same FIFO.
REQ-010 Port: fifo_wr_en  output  1  FIFO write enable.
REQ-011 Port: fifo_din  output  8  FIFO write data.
REQ-012 Port: owner  output  2  index of the currently granted requester; valid only while busy.
REQ-013 Port: busy  output  1  high while in state XFER.

Function
REQ-014 FSM has two states: IDLE and XFER.
REQ-015 IDLE, req != 0: select the first i with req[i]=1, searching from (last+1) mod 4 upward with wrap; register owner=i, clear beat_cnt, enter XFER on the next edge.
REQ-016 IDLE, req == 0: remain in IDLE; owner holds its value.
REQ-017 IDLE drives fifo_wr_en=0 and ack=0; the arbitration cycle is a one-cycle bubble.
REQ-018 XFER, combinational: wr_ok = req[owner] & !fifo_full & !(fifo_rd_en & !fifo_empty).
REQ-019 fifo_wr_en = wr_ok; ack[owner] = wr_ok; all other ack bits are 0.
REQ-020 fifo_din = din[owner] in every cycle, including cycles where fifo_wr_en=0.
REQ-021 The term (fifo_rd_en & !fifo_empty) is a collision stall: the shared FIFO discards simultaneous valid read and write, so no write is issued in that cycle.
REQ-022 XFER, wr_ok=1: increment beat_cnt (3 bits); if beat_cnt == BURST-1, set last=owner and enter IDLE.
REQ-023 XFER, req[owner]=0: set last=owner and enter IDLE regardless of beat_cnt; no word is written in that cycle.
REQ-024 XFER, req[owner]=1 and wr_ok=0 (full or collision stall): hold state, owner and beat_cnt.
REQ-025 Other requesters' req lines have no effect in XFER; there is no preemption.
REQ-026 Fairness: with all four requesters continuously requesting, grants rotate 0,1,2,3,0,... with each grant writing BURST words when not stalled.

Reset
REQ-027 On rst low, immediately and independent of clk: state=IDLE, owner=0, last=3, beat_cnt=0.
REQ-028 Outputs while reset is asserted: fifo_wr_en=0, ack=0, busy=0, owner=0; fifo_din reflects din0.
REQ-029 Reset asserted during XFER aborts the burst with no further write; words already acked remain in the FIFO.
REQ-030 The first edge after rst deasserts arbitrates with requester 0 at highest priority.

Verification
REQ-031 Scenario: rst released, req=4'b0001, din0=8'hA1..A4 for successive words, FIFO empty, fifo_rd_en=0 -> one IDLE bubble, then 4 consecutive cycles with fifo_wr_en=1 and ack=4'b0001, then IDLE.
REQ-032 Scenario: req=4'b1111 held, FIFO drained each bubble, BURST=4 -> owner sequence 0,1,2,3,0, each grant writing 4 words, with exactly one idle cycle between grants.
REQ-033 Scenario: owner=2 writing, fifo_full rises after 3 words -> fifo_wr_en=0, ack=0, beat_cnt=3 held; fifo_full falls -> exactly 1 more word, then IDLE.
REQ-034 Scenario: XFER with fifo_empty=0, fifo_rd_en=1 for 2 cycles -> no write in either cycle, state and beat_cnt unchanged, writes resume the cycle fifo_rd_en falls.
REQ-035 Scenario: owner=1 drops req[1] after 2 words while req[3]=1 -> IDLE next edge, owner=3 the edge after, last=1.
REQ-036 Scenario: rst pulsed low mid-burst between clock edges -> fifo_wr_en, ack and busy fall to 0 without waiting for clk; after release with req=4'b1010 -> owner=1 granted first.
